ripple_count_capture: RTL and testbench

- Downstream consumer of the 4-bit asynchronous ripple counter's `count` bus.
- Brings the glitch-prone ripple outputs into the system `clk` domain and filters out mid-ripple transient codes.
- Converts successive settled codes into modular increments and keeps a wide running total.
- Presents each update on a valid/ready output port.

---
 rtl/ripple_count_capture_pkg.sv | 17 +
 rtl/ripple_count_capture_bus_sync_filter.sv | 41 ++++
 rtl/ripple_count_capture.sv | 112 +++++++++++
 tb/tb_ripple_count_capture.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ripple_count_capture_pkg.sv
// Shared types and constants for the ripple-counter capture block.
package ripple_count_capture_pkg;

   typedef enum logic [1:0] {
      INIT = 2'd0,
      IDLE = 2'd1,
      HOLD = 2'd2
   } state_e;

   localparam int MIN_SYNC_STAGES = 2;

   // Stage count actually built; anything below the minimum is raised to it.
   function automatic int sync_depth(input int requested);
      return (requested < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : requested;
   endfunction

endpackage

// File: rtl/ripple_count_capture_bus_sync_filter.sv
// Multi-flop synchroniser for a ripple bus plus a two-sample stability filter.
module bus_sync_filter
   import ripple_count_capture_pkg::*;
#(
   parameter int W      = 4,
   parameter int STAGES = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] async_in,
   output logic         settled,
   output logic [W-1:0] settled_val
);

   localparam int NS = sync_depth(STAGES);

   logic [NS-1:0][W-1:0] sync_r;
   logic [W-1:0]         prev_q;
   logic [W-1:0]         sync_q;
   // Tracks how far real samples have propagated since reset, so the
   // zeroed flops are never mistaken for a settled code of 0.
   logic [NS:0]          vld_pipe;

   assign sync_q = sync_r[NS-1];

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_r   <= '0;
         prev_q   <= '0;
         vld_pipe <= '0;
      end else begin
         sync_r   <= {sync_r[NS-2:0], async_in};
         prev_q   <= sync_q;
         vld_pipe <= {vld_pipe[NS-1:0], 1'b1};
      end
   end

   assign settled     = vld_pipe[NS] && (sync_q == prev_q);
   assign settled_val = sync_q;

endmodule

// File: rtl/ripple_count_capture.sv
// Captures a ripple counter into clk, turns settled codes into increments and reports them on valid/ready.
module ripple_count_capture
   import ripple_count_capture_pkg::*;
#(
   parameter int CNT_W       = 4,
   parameter int ACC_W       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [CNT_W-1:0] async_count,
   input  logic             clear,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [ACC_W-1:0] out_total,
   output logic [ACC_W-1:0] out_delta,
   output logic             overflow
);

   logic             settled;
   logic [CNT_W-1:0] settled_val;

   bus_sync_filter #(
      .W      (CNT_W),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk         (clk),
      .reset       (reset),
      .async_in    (async_count),
      .settled     (settled),
      .settled_val (settled_val)
   );

   state_e           state;
   logic [CNT_W-1:0] base;
   logic [ACC_W-1:0] total;
   logic [ACC_W-1:0] pending;

   logic             have_d;
   logic [CNT_W-1:0] diff;
   logic [ACC_W-1:0] d_eff;
   logic [ACC_W:0]   tot_sum;
   logic [ACC_W:0]   pend_sum;
   logic [ACC_W-1:0] pend_sat;

   // Modular difference handles counter wrap (15 -> 0 gives 1).
   always_comb begin
      have_d   = settled && (settled_val != base) && (state != INIT);
      diff     = settled_val - base;
      d_eff    = have_d ? ACC_W'(diff) : '0;
      tot_sum  = {1'b0, total} + {1'b0, d_eff};
      pend_sum = {1'b0, pending} + {1'b0, d_eff};
      pend_sat = pend_sum[ACC_W] ? '1 : pend_sum[ACC_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         state     <= INIT;
         total     <= '0;
         pending   <= '0;
         overflow  <= 1'b0;
         out_valid <= 1'b0;
         out_total <= '0;
         out_delta <= '0;
         if (reset) base <= '0;
      end else begin
         if (have_d) begin
            base  <= settled_val;
            total <= tot_sum[ACC_W-1:0];
            if (tot_sum[ACC_W]) overflow <= 1'b1;
         end

         case (state)
            INIT: begin
               if (settled) begin
                  base  <= settled_val;
                  state <= IDLE;
               end
            end

            IDLE: begin
               if (have_d) begin
                  out_delta <= d_eff;
                  out_total <= tot_sum[ACC_W-1:0];
                  out_valid <= 1'b1;
                  state     <= HOLD;
               end
            end

            HOLD: begin
               if (pend_sum[ACC_W]) overflow <= 1'b1;
               if (out_ready) begin
                  // Anything gathered while stalled goes out back-to-back.
                  if (pend_sat != '0) begin
                     out_delta <= pend_sat;
                     out_total <= tot_sum[ACC_W-1:0];
                     pending   <= '0;
                  end else begin
                     out_valid <= 1'b0;
                     state     <= IDLE;
                  end
               end else begin
                  pending <= pend_sat;
               end
            end

            default: state <= INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_ripple_count_capture.sv
// Directed + randomized bench for ripple_count_capture against a transaction-level increment model.
module tb_ripple_count_capture;

   localparam int CNT_W = 4;
   localparam int ACC_W = 6;
   localparam int MODC  = 1 << CNT_W;
   localparam int MODA  = 1 << ACC_W;

   logic             clk = 1'b0;
   logic             reset;
   logic [CNT_W-1:0] async_count;
   logic             clear;
   logic             out_ready;
   logic             out_valid;
   logic [ACC_W-1:0] out_total;
   logic [ACC_W-1:0] out_delta;
   logic             overflow;

   ripple_count_capture #(
      .CNT_W       (CNT_W),
      .ACC_W       (ACC_W),
      .SYNC_STAGES (2)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .async_count (async_count),
      .clear       (clear),
      .out_ready   (out_ready),
      .out_valid   (out_valid),
      .out_total   (out_total),
      .out_delta   (out_delta),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      int d;
      int t;
   } upd_t;

   upd_t expq[$];
   upd_t obsq[$];

   int checks = 0;
   int passes = 0;

   // Reference model: counts input increments, not RTL state.
   int mcode, mtotal, mpend;
   bit moverflow, outstanding;

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      checks++;
      assert (o === e) passes++;
      else $error("FAIL %s: got %0d expected %0d", tag, o, e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      mtotal      = 0;
      mpend       = 0;
      moverflow   = 0;
      outstanding = 0;
   endtask

   task automatic model_step(input int code);
      int d;
      d     = (code - mcode + MODC) % MODC;
      mcode = code;
      if (d == 0) return;
      if (mtotal + d >= MODA) moverflow = 1;
      mtotal = (mtotal + d) % MODA;
      if (outstanding) begin
         mpend += d;
         if (mpend > MODA - 1) begin
            mpend     = MODA - 1;
            moverflow = 1;
         end
      end else begin
         expq.push_back('{d, mtotal});
         if (!out_ready) outstanding = 1;
      end
   endtask

   task automatic step(input int code);
      async_count = CNT_W'(code % MODC);
      repeat (8) tick();
      model_step(code % MODC);
      chk("overflow", overflow, moverflow);
   endtask

   task automatic set_ready(input logic v);
      out_ready = v;
      if (v && outstanding) begin
         outstanding = 0;
         if (mpend != 0) expq.push_back('{mpend, mtotal});
         mpend = 0;
      end
      repeat (4) tick();
   endtask

   task automatic drain();
      upd_t e, o;
      while (expq.size() > 0 && obsq.size() > 0) begin
         e = expq.pop_front();
         o = obsq.pop_front();
         chk("upd_delta", o.d, e.d);
         chk("upd_total", o.t, e.t);
      end
      chk("upd_count", obsq.size(), expq.size());
      expq.delete();
      obsq.delete();
   endtask

   // Handshake monitor and stable-while-stalled check.
   logic pv = 1'b0, pr = 1'b0;
   logic [ACC_W-1:0] pd = '0, pt = '0;
   always @(negedge clk) begin
      if (!reset) begin
         if (out_valid && out_ready) obsq.push_back('{int'(out_delta), int'(out_total)});
         if (pv && !pr && out_valid) begin
            chk("stall_delta", out_delta, pd);
            chk("stall_total", out_total, pt);
         end
      end
      pv = out_valid;
      pr = out_ready;
      pd = out_delta;
      pt = out_total;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset       = 1'b1;
      clear       = 1'b0;
      out_ready   = 1'b1;
      async_count = 4'd5;
      mcode       = 5;
      model_reset();
      repeat (3) tick();
      chk("rst_valid", out_valid, 0);
      chk("rst_total", out_total, 0);
      chk("rst_delta", out_delta, 0);
      chk("rst_ovf", overflow, 0);
      reset = 1'b0;

      // Baseline only.
      repeat (10) tick();
      chk("base_valid", out_valid, 0);
      chk("base_total", out_total, 0);
      chk("base_obs", obsq.size(), 0);

      // Latency of first update.
      async_count = 4'd6;
      repeat (3) tick();
      chk("lat_early", out_valid, 0);
      tick();
      chk("lat_valid", out_valid, 1);
      chk("lat_delta", out_delta, 1);
      repeat (5) tick();
      model_step(6);
      step(7);
      drain();

      // One-cycle glitch must be ignored.
      step(13);
      async_count = 4'd8;
      tick();
      step(14);
      drain();

      step(15);
      step(0);
      step(3);
      step(2);
      drain();

      // Back-pressure: outputs freeze, pending collects the rest.
      set_ready(1'b0);
      step(3);
      step(4);
      step(5);
      step(6);
      chk("frz_valid", out_valid, 1);
      chk("frz_delta", out_delta, 1);
      chk("frz_total", out_total, 30);
      set_ready(1'b1);
      chk("rel_valid", out_valid, 0);
      drain();

      // Directed wrap of the 6-bit total, then randomized traffic.
      for (int i = 0; i < 3; i++) step(mcode + 15);
      drain();
      chk("wrap_ovf", overflow, 1);
      for (int i = 0; i < 20; i++) begin
         if ($urandom_range(0, 3) == 0) set_ready(!out_ready);
         step(mcode + int'($urandom_range(1, 15)));
         if (out_ready) drain();
      end
      set_ready(1'b1);
      drain();

      // clear while holding an update.
      set_ready(1'b0);
      step(mcode + 1);
      chk("pre_clr_valid", out_valid, 1);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("clr_valid", out_valid, 0);
      chk("clr_total", out_total, 0);
      chk("clr_delta", out_delta, 0);
      chk("clr_ovf", overflow, 0);
      void'(expq.pop_back());
      model_reset();
      repeat (4) tick();
      set_ready(1'b1);
      step(mcode + 1);
      drain();

      // Reset while holding an update.
      set_ready(1'b0);
      step(mcode + 2);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rsthold_valid", out_valid, 0);
      void'(expq.pop_back());
      model_reset();
      repeat (6) tick();
      set_ready(1'b1);
      step(mcode + 3);
      drain();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
